// File: rtl/cpu_pkg.sv
// Shared encodings for the 8-bit CPU control path: opcodes, ALU ops, B-mux selects, FSM states.
package cpu_pkg;

  localparam logic [6:0] OP_NOP    = 7'h00;
  localparam logic [6:0] OP_MOV_AB = 7'h01;
  localparam logic [6:0] OP_MOV_BA = 7'h02;
  localparam logic [6:0] OP_MOV_AL = 7'h03;
  localparam logic [6:0] OP_MOV_BL = 7'h04;
  localparam logic [6:0] OP_ADD_AB = 7'h05;
  localparam logic [6:0] OP_ADD_AL = 7'h06;
  localparam logic [6:0] OP_SUB_AB = 7'h07;
  localparam logic [6:0] OP_SUB_AL = 7'h08;
  localparam logic [6:0] OP_AND_AB = 7'h09;
  localparam logic [6:0] OP_OR_AB  = 7'h0A;
  localparam logic [6:0] OP_JMP    = 7'h0B;
  localparam logic [6:0] OP_HALT   = 7'h7F;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  // 2'b11 is reserved and never driven
  localparam logic [1:0] SB_B    = 2'b00;
  localparam logic [1:0] SB_LIT  = 2'b01;
  localparam logic [1:0] SB_ZERO = 2'b10;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_HALT   = 2'd3
  } state_t;

endpackage

// File: rtl/control_decoder.sv
// Opcode decoder: pure combinational map from opcode to datapath controls and jump/halt flags.
// Unknown opcodes decode as NOP.
module control_decoder
  import cpu_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       la,
  output logic       lb,
  output logic       sa,
  output logic [1:0] sb,
  output logic [2:0] alu_op,
  output logic       is_jmp,
  output logic       is_halt
);

  always_comb begin
    la      = 1'b0;
    lb      = 1'b0;
    sa      = 1'b0;
    sb      = SB_B;
    alu_op  = ALU_ADD;
    is_jmp  = 1'b0;
    is_halt = 1'b0;
    case (opcode)
      OP_MOV_AB: begin la = 1'b1; sa = 1'b1; end
      OP_MOV_BA: begin lb = 1'b1; sb = SB_ZERO; end
      OP_MOV_AL: begin la = 1'b1; sa = 1'b1; sb = SB_LIT; end
      OP_MOV_BL: begin lb = 1'b1; sa = 1'b1; sb = SB_LIT; end
      OP_ADD_AB: begin la = 1'b1; end
      OP_ADD_AL: begin la = 1'b1; sb = SB_LIT; end
      OP_SUB_AB: begin la = 1'b1; alu_op = ALU_SUB; end
      OP_SUB_AL: begin la = 1'b1; sb = SB_LIT; alu_op = ALU_SUB; end
      OP_AND_AB: begin la = 1'b1; alu_op = ALU_AND; end
      OP_OR_AB:  begin la = 1'b1; alu_op = ALU_OR; end
      OP_JMP:    is_jmp = 1'b1;
      OP_HALT:   is_halt = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC, 3 cycles per instruction, controls valid only in EXEC.
// en low freezes state/pc/ir and forces all controls to their idle defaults.
module control_unit
  import cpu_pkg::*;
#(
  parameter int AW = 8,
  parameter int IW = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic [AW-1:0] rom_addr,
  input  logic [IW-1:0] rom_data,
  output logic [AW-1:0] pc,
  output logic          la,
  output logic          lb,
  output logic          sa,
  output logic [1:0]    sb,
  output logic [2:0]    alu_op,
  output logic [7:0]    literal,
  output logic          halted
);

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] ir;
  logic [AW-1:0] pc_nxt;
  logic [AW-1:0] jmp_tgt;

  logic       d_la;
  logic       d_lb;
  logic       d_sa;
  logic [1:0] d_sb;
  logic [2:0] d_alu_op;
  logic       d_jmp;
  logic       d_halt;

  control_decoder u_dec (
    .opcode  (ir[IW-1:IW-7]),
    .la      (d_la),
    .lb      (d_lb),
    .sa      (d_sa),
    .sb      (d_sb),
    .alu_op  (d_alu_op),
    .is_jmp  (d_jmp),
    .is_halt (d_halt)
  );

  assign jmp_tgt  = AW'(ir[7:0]);
  assign rom_addr = pc;
  assign literal  = ir[7:0];
  assign halted   = (state == ST_HALT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_FETCH;
      pc    <= '0;
      ir    <= '0;
    end else if (en) begin
      state <= state_nxt;
      pc    <= pc_nxt;
      // ROM data for address pc arrives one cycle after FETCH
      if (state == ST_DECODE) ir <= rom_data;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      ST_FETCH:  state_nxt = ST_DECODE;
      ST_DECODE: state_nxt = ST_EXEC;
      ST_EXEC: begin
        pc_nxt    = d_jmp ? jmp_tgt : pc + AW'(1);
        state_nxt = d_halt ? ST_HALT : ST_FETCH;
      end
      ST_HALT:   state_nxt = ST_HALT;
      default:   state_nxt = ST_FETCH;
    endcase
  end

  // Gating with en keeps a stalled EXEC from stretching a strobe
  always_comb begin
    la     = 1'b0;
    lb     = 1'b0;
    sa     = 1'b0;
    sb     = SB_B;
    alu_op = ALU_ADD;
    if (en && state == ST_EXEC) begin
      la     = d_la;
      lb     = d_lb;
      sa     = d_sa;
      sb     = d_sb;
      alu_op = d_alu_op;
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Randomized scoreboard bench for control_unit: an instruction-level model of the program queues
// expected EXEC controls; a monitor pops and compares them as the DUT reaches each EXEC cycle.
module tb_control_unit;

  localparam int NSCEN = 24;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic [7:0]  rom_addr;
  logic [14:0] rom_data;
  logic [7:0]  pc;
  logic        la, lb, sa;
  logic [1:0]  sb;
  logic [2:0]  alu_op;
  logic [7:0]  literal;
  logic        halted;

  always #5 clk = ~clk;

  control_unit #(.AW(8), .IW(15)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .pc       (pc),
    .la       (la),
    .lb       (lb),
    .sa       (sa),
    .sb       (sb),
    .alu_op   (alu_op),
    .literal  (literal),
    .halted   (halted)
  );

  logic [14:0] rom [256];
  always_ff @(posedge clk) rom_data <= rom[rom_addr];

  typedef struct {
    logic [7:0] pc;
    logic [7:0] ctl;   // {la, lb, sa, sb[1:0], alu_op[2:0]}
    logic [7:0] lit;
    bit         halt;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  int         phase = 0;
  bit         m_halted = 1'b0;
  logic [7:0] m_hpc = 8'h00;
  logic [7:0] dut_ctl;

  assign dut_ctl = {la, lb, sa, sb, alu_op};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Decode table as written in the instruction set description
  function automatic logic [7:0] spec_ctl(input logic [6:0] op);
    case (op)
      7'h01:   return {1'b1, 1'b0, 1'b1, 2'b00, 3'd0};
      7'h02:   return {1'b0, 1'b1, 1'b0, 2'b10, 3'd0};
      7'h03:   return {1'b1, 1'b0, 1'b1, 2'b01, 3'd0};
      7'h04:   return {1'b0, 1'b1, 1'b1, 2'b01, 3'd0};
      7'h05:   return {1'b1, 1'b0, 1'b0, 2'b00, 3'd0};
      7'h06:   return {1'b1, 1'b0, 1'b0, 2'b01, 3'd0};
      7'h07:   return {1'b1, 1'b0, 1'b0, 2'b00, 3'd1};
      7'h08:   return {1'b1, 1'b0, 1'b0, 2'b01, 3'd1};
      7'h09:   return {1'b1, 1'b0, 1'b0, 2'b00, 3'd2};
      7'h0A:   return {1'b1, 1'b0, 1'b0, 2'b00, 3'd3};
      default: return 8'h00;
    endcase
  endfunction

  // Instruction-level execution of the program in rom, starting at address 0
  task automatic run_model(input int n);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < n; i++) begin
      logic [14:0] ins;
      exp_t        e;
      ins    = rom[p];
      e.pc   = p;
      e.ctl  = spec_ctl(ins[14:8]);
      e.lit  = ins[7:0];
      e.halt = (ins[14:8] == 7'h7F);
      q.push_back(e);
      if (e.halt) break;
      p = (ins[14:8] == 7'h0B) ? ins[7:0] : p + 8'd1;
    end
  endtask

  task automatic load_program(input int s);
    for (int a = 0; a < 256; a++) begin
      int r;
      logic [6:0] op;
      r = $urandom_range(0, 15);
      if (r <= 11)      op = 7'(r);
      else if (r == 12) op = 7'h7F;
      else if (r == 13) op = 7'h0B;
      else              op = 7'($urandom_range(0, 127));
      rom[a] = {op, 8'($urandom_range(0, 255))};
    end
    case (s)
      0: begin
        rom[0] = {7'h03, 8'h05};
        rom[1] = {7'h04, 8'h03};
        rom[2] = {7'h05, 8'h00};
      end
      1: begin
        rom[0]   = {7'h0B, 8'hFE};
        rom[254] = {7'h00, 8'h00};
        rom[255] = {7'h00, 8'h00};
      end
      2: rom[0] = {7'h7F, 8'h00};
      3: rom[0] = {7'h07, 8'h00};
      4: rom[0] = {7'h55, 8'hAA};
      default: ;
    endcase
  endtask

  // Monitor: phase counts enabled edges since reset; phase 2 is the EXEC cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        phase    = 0;
        m_halted = 1'b0;
        chk("reset_pc", pc, 8'h00);
        chk("reset_ctl", dut_ctl, 8'h00);
        chk("reset_halted", halted, 1'b0);
      end else begin
        chk("halted", halted, m_halted);
        if (m_halted) begin
          chk("halt_pc", pc, m_hpc);
          chk("halt_ctl", dut_ctl, 8'h00);
        end else if (q.size() == 0) begin
          chk("idle_ctl", dut_ctl, 8'h00);
        end else begin
          chk("pc", pc, q[0].pc);
          chk("rom_addr", rom_addr, q[0].pc);
          if (en && phase == 2) begin
            e = q.pop_front();
            chk("exec_ctl", dut_ctl, e.ctl);
            chk("exec_literal", literal, e.lit);
            if (e.halt) begin
              m_halted = 1'b1;
              m_hpc    = e.pc + 8'd1;
            end
          end else begin
            chk("nonexec_ctl", dut_ctl, 8'h00);
          end
          if (en) phase = (phase + 1) % 3;
        end
      end
    end
  end

  initial begin
    int  budget;
    int  k;
    bit  mid;
    reset = 1'b1;
    en    = 1'b0;
    for (int a = 0; a < 256; a++) rom[a] = '0;
    @(posedge clk);
    #1;
    for (int s = 0; s < NSCEN; s++) begin
      reset = 1'b1;
      en    = 1'($urandom_range(0, 1));
      q.delete();
      load_program(s);
      run_model(30);
      repeat (2) @(posedge clk);
      #1;
      reset  = 1'b0;
      budget = 0;
      mid    = (s >= 5) && (s % 3 == 0);
      k      = $urandom_range(2, 25);
      while (q.size() != 0 && budget < 2000 && !(mid && budget >= k && phase == 1)) begin
        en = (s == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        @(posedge clk);
        #1;
        budget++;
      end
      if (budget >= 2000) begin
        checks++;
        errors++;
        $display("FAIL timeout: scenario %0d got %0d pending entries, expected 0", s, q.size());
      end
      if (m_halted) begin
        repeat (20) begin
          en = 1'b1;
          @(posedge clk);
          #1;
        end
      end
    end
    reset = 1'b1;
    q.delete();
    repeat (2) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
